// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter:
// FSM states, requester IDs, burst limit and the latched request bundle.
package mem_arbiter_pkg;

  localparam int BEATS_MAX = 8;
  localparam int CNT_W     = $clog2(BEATS_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick between ic (index 0) and dc (index 1).
// Ports: valid[1:0] request bits, last_grant previous winner, grant winner ID.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = REQ_IC;
    unique case (valid)
      2'b01:   grant = REQ_IC;
      2'b10:   grant = REQ_DC;
      2'b11:   grant = ~last_grant;
      default: grant = REQ_IC;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter: ic line refills and dc reads/writes
// share one memory port. Ports: clk/reset, ic_req_*/ic_resp_*,
// dc_req_*/dc_resp_*, mem_req_*/mem_resp_*, stall to the pipeline.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_req_valid,
  input  logic [31:0] ic_req_addr,
  output logic        ic_req_ready,
  output logic        ic_resp_valid,
  output logic [31:0] ic_resp_data,
  output logic        ic_resp_last,
  input  logic        dc_req_valid,
  input  logic [31:0] dc_req_addr,
  input  logic        dc_req_wr,
  input  logic [31:0] dc_req_wdata,
  input  logic [3:0]  dc_req_wmask,
  output logic        dc_req_ready,
  output logic        dc_resp_valid,
  output logic [31:0] dc_resp_data,
  output logic        dc_resp_last,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        stall
);

  localparam logic [31:0] LINE_MASK =
    ~(32'(BEATS * 4) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(BEATS - 1);

  logic [1:0]       state;
  logic             gnt_id;
  logic             last_grant;
  logic [CNT_W-1:0] beat_cnt;
  mem_req_t         lat;
  mem_req_t         nxt_req;

  logic any_req;
  logic sel;
  logic grant_fire;
  logic beat;
  logic is_last;

  assign any_req = ic_req_valid | dc_req_valid;

  rr_arb2 u_rr (
    .valid      ({dc_req_valid, ic_req_valid}),
    .last_grant (last_grant),
    .grant      (sel)
  );

  // Combinational outputs are gated by reset so nothing
  // leaks out during the reset cycle itself.
  assign grant_fire = !reset && state == ST_IDLE && any_req;

  always_comb begin
    nxt_req = '0;
    if (sel == REQ_DC && dc_req_wr) begin
      nxt_req.addr  = dc_req_addr & ~32'h3;
      nxt_req.wr    = 1'b1;
      nxt_req.wdata = dc_req_wdata;
      nxt_req.wmask = dc_req_wmask;
    end else if (sel == REQ_DC) begin
      nxt_req.addr = dc_req_addr & LINE_MASK;
    end else begin
      nxt_req.addr = ic_req_addr & LINE_MASK;
    end
  end

  assign beat    = !reset && state == ST_WAIT && mem_resp_valid;
  assign is_last = lat.wr || beat_cnt == LAST_BEAT;

  assign ic_req_ready  = grant_fire && sel == REQ_IC;
  assign dc_req_ready  = grant_fire && sel == REQ_DC;

  assign ic_resp_valid = beat && gnt_id == REQ_IC;
  assign dc_resp_valid = beat && gnt_id == REQ_DC;
  assign ic_resp_last  = ic_resp_valid && is_last;
  assign dc_resp_last  = dc_resp_valid && is_last;
  assign ic_resp_data  = ic_resp_valid ? mem_resp_data : '0;
  assign dc_resp_data  =
    (dc_resp_valid && !lat.wr) ? mem_resp_data : '0;

  assign mem_req_valid = !reset && state == ST_ISSUE;
  assign mem_req_addr  = lat.addr;
  assign mem_req_wr    = lat.wr;
  assign mem_req_wdata = lat.wdata;
  assign mem_req_wmask = lat.wmask;

  assign stall = ic_req_valid || dc_req_valid || state != ST_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt_id     <= REQ_IC;
      last_grant <= REQ_IC;
      beat_cnt   <= '0;
      lat        <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            lat        <= nxt_req;
            gnt_id     <= sel;
            last_grant <= sel;
            beat_cnt   <= '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            if (is_last) begin
              state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter with an
// in-bench round-robin / burst reference model.
module tb_mem_arbiter;

  localparam int BEATS = 4;

  logic        clk;
  logic        reset;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        ic_resp_last;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic        dc_req_wr;
  logic [31:0] dc_req_wdata;
  logic [3:0]  dc_req_wmask;
  logic        dc_req_ready;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        dc_resp_last;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        stall;

  int checks = 0;
  int errors = 0;
  bit last_dc;
  bit obs_dc;

  mem_arbiter #(.BEATS(BEATS)) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .ic_resp_last   (ic_resp_last),
    .dc_req_valid   (dc_req_valid),
    .dc_req_addr    (dc_req_addr),
    .dc_req_wr      (dc_req_wr),
    .dc_req_wdata   (dc_req_wdata),
    .dc_req_wmask   (dc_req_wmask),
    .dc_req_ready   (dc_req_ready),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_data   (dc_resp_data),
    .dc_resp_last   (dc_resp_last),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wr     (mem_req_wr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_icr"}, ic_req_ready, 0);
    chk({tag, "_dcr"}, dc_req_ready, 0);
    chk({tag, "_icv"}, ic_resp_valid, 0);
    chk({tag, "_dcv"}, dc_resp_valid, 0);
    chk({tag, "_icl"}, ic_resp_last, 0);
    chk({tag, "_dcl"}, dc_resp_last, 0);
    chk({tag, "_mrv"}, mem_req_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1; ic_req_valid = 1; dc_req_valid = 1;
    mem_resp_valid = 1; mem_req_ready = 1;
    #1 chk_quiet("in_reset");
    step();
    chk_quiet("in_reset2");
    step();
    reset = 0; ic_req_valid = 0; dc_req_valid = 0;
    mem_resp_valid = 0; mem_req_ready = 0;
    last_dc = 0;
    #1;
    chk_quiet("post_reset");
    chk("post_reset_stall", stall, 0);
    chk("post_reset_addr", mem_req_addr, 0);
  endtask

  // Entered one step after a clock edge with requests driven and
  // the arbiter idle; runs one whole transaction to completion.
  task automatic txn(input int stalls, input bit drop);
    bit edc, ew;
    logic [31:0] ea, ewd, d;
    logic [3:0] ewm;
    int nb;
    edc = (ic_req_valid && dc_req_valid) ? !last_dc
                                         : dc_req_valid;
    ew = edc && dc_req_wr;
    ewd = dc_req_wdata;
    if (ew) begin
      ea = dc_req_addr - (dc_req_addr % 4);
      ewm = dc_req_wmask;
    end else begin
      ea = edc ? dc_req_addr : ic_req_addr;
      ea = ea - (ea % (BEATS * 4));
      ewm = 4'h0;
    end
    #1;
    chk("grant_ic", ic_req_ready, !edc);
    chk("grant_dc", dc_req_ready, edc);
    chk("grant_stall", stall, 1);
    chk("grant_mrv", mem_req_valid, 0);
    obs_dc = dc_req_ready;
    step();
    last_dc = edc;
    if (drop) begin
      if (edc) begin
        dc_req_valid = 0; dc_req_addr = $urandom;
        dc_req_wdata = $urandom; dc_req_wr = 1'($urandom);
        dc_req_wmask = 4'($urandom);
      end else begin
        ic_req_valid = 0; ic_req_addr = $urandom;
      end
    end
    for (int i = 0; i <= stalls; i++) begin
      mem_req_ready = (i == stalls);
      #1;
      chk("issue_valid", mem_req_valid, 1);
      chk("issue_addr", mem_req_addr, ea);
      chk("issue_wr", mem_req_wr, ew);
      chk("issue_wmask", mem_req_wmask, ewm);
      if (ew) chk("issue_wdata", mem_req_wdata, ewd);
      chk("issue_icr", ic_req_ready, 0);
      chk("issue_dcr", dc_req_ready, 0);
      chk("issue_stall", stall, 1);
      step();
    end
    mem_req_ready = 0;
    nb = ew ? 1 : BEATS;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 2)) begin
        mem_resp_valid = 0;
        #1;
        chk("gap_icv", ic_resp_valid, 0);
        chk("gap_dcv", dc_resp_valid, 0);
        chk("gap_mrv", mem_req_valid, 0);
        chk("gap_stall", stall, 1);
        step();
      end
      mem_resp_valid = 1;
      d = $urandom;
      mem_resp_data = d;
      #1;
      chk("beat_icv", ic_resp_valid, !edc);
      chk("beat_dcv", dc_resp_valid, edc);
      chk("beat_icl", ic_resp_last, !edc && b == nb - 1);
      chk("beat_dcl", dc_resp_last, edc && b == nb - 1);
      if (!ew) chk("beat_data", edc ? dc_resp_data
                                    : ic_resp_data, d);
      chk("beat_icr", ic_req_ready, 0);
      chk("beat_dcr", dc_req_ready, 0);
      step();
    end
    mem_resp_valid = 0;
  endtask

  initial begin
    reset = 1; ic_req_valid = 0; ic_req_addr = 0;
    dc_req_valid = 0; dc_req_addr = 0; dc_req_wr = 0;
    dc_req_wdata = 0; dc_req_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    last_dc = 0; obs_dc = 0;

    do_reset();

    // stray memory beat while idle
    mem_resp_valid = 1; mem_resp_data = 32'h1111_2222;
    #1;
    chk_quiet("idle_stray");
    chk("idle_stray_stall", stall, 0);
    step();
    mem_resp_valid = 0;

    // single ic refill at 0x1234
    ic_req_valid = 1; ic_req_addr = 32'h0000_1234;
    txn(0, 1);
    #1 chk("after_ic_stall", stall, 0);
    step();

    // simultaneous requests after reset: dc then ic
    do_reset();
    ic_req_valid = 1; ic_req_addr = 32'h0000_0040;
    dc_req_valid = 1; dc_req_addr = 32'h0000_0080;
    dc_req_wr = 0;
    txn(1, 1);
    chk("conflict_first_dc", obs_dc, 1);
    txn(0, 1);
    chk("conflict_second_ic", obs_dc, 0);

    // dc write with three cycles of backpressure
    dc_req_valid = 1; dc_req_addr = 32'h0000_0100;
    dc_req_wr = 1; dc_req_wdata = 32'hDEAD_BEEF;
    dc_req_wmask = 4'h3;
    txn(3, 1);
    #1 chk("after_wr_stall", stall, 0);
    step();

    // both held for four transactions
    do_reset();
    ic_req_valid = 1; ic_req_addr = 32'h0000_2004;
    dc_req_valid = 1; dc_req_addr = 32'h0000_3008;
    dc_req_wr = 0;
    for (int k = 0; k < 4; k++) begin
      txn(k % 2, 0);
      chk("held_order", obs_dc, (k % 2) == 0);
    end
    ic_req_valid = 0; dc_req_valid = 0;
    step();

    // reset on beat 2 of an ic refill
    do_reset();
    ic_req_valid = 1; ic_req_addr = 32'h0000_0500;
    #1 chk("rst_mid_grant", ic_req_ready, 1);
    step();
    ic_req_valid = 0; mem_req_ready = 1;
    #1 chk("rst_mid_issue", mem_req_valid, 1);
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1; mem_resp_data = $urandom;
      #1 chk("rst_mid_beat", ic_resp_valid, 1);
      step();
    end
    reset = 1;
    #1 chk("rst_mid_during", ic_resp_valid, 0);
    step();
    reset = 0;
    last_dc = 0;
    #1;
    chk_quiet("rst_mid_after");
    chk("rst_mid_stall", stall, 0);
    step();
    chk("rst_mid_stray_icv", ic_resp_valid, 0);
    chk("rst_mid_stray_stall", stall, 0);
    step();
    mem_resp_valid = 0;

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!ic_req_valid && $urandom_range(0, 1) == 1) begin
        ic_req_valid = 1; ic_req_addr = $urandom;
      end
      if (!dc_req_valid &&
          ($urandom_range(0, 1) == 1 || !ic_req_valid)) begin
        dc_req_valid = 1; dc_req_addr = $urandom;
        dc_req_wr = 1'($urandom);
        dc_req_wdata = $urandom;
        dc_req_wmask = 4'($urandom);
      end
      txn(int'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0);
    end
    ic_req_valid = 0; dc_req_valid = 0;
    #1 chk("final_stall", stall, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BEATS, default 4, SHALL set the read-burst length in 32-bit words; legal values are 1, 2, 4 and 8.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ic_req_valid  input  1  instruction-side line-refill request.
REQ-005 ic_req_addr  input  32  instruction-side line address; bits [1:0] ignored.
REQ-006 ic_req_ready  output  1  instruction-side request accepted this cycle.
REQ-007 ic_resp_valid / ic_resp_data / ic_resp_last  output  1/32/1  instruction-side refill beat, data, final-beat flag.
REQ-008 dc_req_valid / dc_req_addr / dc_req_wr  input  1/32/1  data-side request, address, and write flag (1 = single-word write).
REQ-009 dc_req_wdata / dc_req_wmask  input  32/4  data-side write data and byte enables.
REQ-010 dc_req_ready  output  1  data-side request accepted.
REQ-011 dc_resp_valid / dc_resp_data / dc_resp_last  output  1/32/1  data-side read beat or write acknowledge.
REQ-012 mem_req_valid / mem_req_ready  output/input  1/1  memory-port request handshake.
REQ-013 mem_req_addr / mem_req_wr / mem_req_wdata / mem_req_wmask  output  32/1/32/4  memory-port request fields.
REQ-014 mem_resp_valid / mem_resp_data  input  1/32  memory-port response beat.
REQ-015 stall  output  1  pipeline-hold request to the stage registers.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and WAIT; at most one transaction SHALL be outstanding.
REQ-017 IDLE: with any request valid, the arbiter SHALL select one requester, latch its fields, assert that requester's req_ready for exactly one cycle, and move to ISSUE.
REQ-018 With a single valid request, that requester SHALL be selected.
REQ-019 With both requests valid, the requester not granted last SHALL be selected (round-robin); after reset, dc SHALL win the first conflict.
REQ-020 ISSUE: mem_req_valid=1 with the latched fields; on mem_req_valid&&mem_req_ready the FSM SHALL move to WAIT, otherwise it SHALL hold all fields stable.
REQ-021 A read SHALL start at the BEATS-word-aligned address; mem_req_wr=0 and mem_req_wmask=0.
REQ-022 A write (dc only) SHALL issue the address word-aligned, with wdata and wmask passed unchanged.
REQ-023 WAIT, read: each mem_resp_valid SHALL be forwarded the same cycle (combinational) to the granted requester's resp_valid and resp_data.
REQ-024 A beat counter SHALL count from 0 to BEATS-1; resp_last SHALL be asserted on beat BEATS-1, and the FSM SHALL then go to IDLE.
REQ-025 WAIT, write: the first mem_resp_valid SHALL produce dc_resp_valid=1 and dc_resp_last=1 with data ignored; the FSM SHALL then go to IDLE.
REQ-026 Responses SHALL never be routed to the non-granted requester; mem_resp_valid in IDLE or ISSUE SHALL be ignored.
REQ-027 A new grant SHALL NOT occur in the cycle the FSM returns to IDLE; the minimum spacing is one IDLE cycle between transactions.
REQ-028 stall SHALL equal (ic_req_valid || dc_req_valid || state != IDLE).
REQ-029 Requesters SHALL hold request fields until their req_ready; the arbiter SHALL NOT depend on them after the grant.

Reset
REQ-030 On reset the arbiter SHALL enter IDLE, clear the beat counter, and set the last-grant value to ic.
REQ-031 During and after reset, all req_ready, resp_valid, resp_last and mem_req_valid outputs SHALL be 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction; later stray mem_resp_valid beats SHALL be ignored under REQ-026.

Structure
REQ-033 The FSM state encoding and the requester ID encoding (IC=0, DC=1) SHALL be defined in the shared package together with BEATS_MAX=8.
REQ-034 The round-robin selection SHALL be one sub-module, rr_arb2 (inputs: two valid bits and last-grant; output: grant index).

Verification
REQ-035 Single ic read at 0x0000_1234 with BEATS=4 -> mem_req_addr=0x0000_1230, four ic_resp beats, ic_resp_last on the 4th beat only.
REQ-036 Simultaneous ic and dc requests after reset -> dc granted first, ic granted second, with at least one IDLE cycle between them.
REQ-037 dc write to 0x100 with wdata 0xDEADBEEF, wmask 0x3 and mem_req_ready held low for 3 cycles -> fields stable across the stall; one dc_resp with last=1.
REQ-038 Both requests held continuously for 4 transactions -> grant order dc, ic, dc, ic; stall=1 throughout.
REQ-039 Reset asserted on beat 2 of an ic refill -> next cycle all outputs 0, state IDLE; remaining memory beats produce no resp_valid.
REQ-040 mem_resp_valid pulsed while in IDLE -> no requester resp_valid is asserted.
